// File: rtl/poly_add_ctrl.sv
// Streams two coefficient banks through an external modular adder and writes
// the sums back in address order: read, one cycle of bank latency, then register.
module poly_add_ctrl #(
    parameter int N  = 256,
    parameter int AW = 8,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_a,
    input  logic [DW-1:0] rd_b,
    output logic [DW-1:0] add_a,
    output logic [DW-1:0] add_b,
    input  logic [DW-1:0] add_res,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    // One extra counter bit lets N = 2**AW be expressed without wrapping.
    localparam logic [AW:0] LAST = (AW+1)'(N - 1);

    state_t        state;
    logic [AW:0]   cnt;
    logic          rv;
    logic [AW-1:0] rv_addr;

    assign rd_addr = cnt[AW-1:0];
    assign add_a   = rd_a;
    assign add_b   = rd_b;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data path registers are reset too, so every output is defined
        // while rst_n is low rather than only the control bits.
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rv      <= 1'b0;
            rv_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            rv      <= rd_en;
            rv_addr <= rd_addr;
            wr_en   <= rv;
            if (rv) begin
                wr_addr <= rv_addr;
                wr_data <= add_res;
            end
            done <= 1'b0;

            if (abort && state != IDLE) begin
                // Kill every pipeline stage so no stale write escapes.
                state <= IDLE;
                busy  <= 1'b0;
                rd_en <= 1'b0;
                rv    <= 1'b0;
                wr_en <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                            rd_en <= 1'b1;
                            cnt   <= '0;
                        end
                    end
                    ISSUE: begin
                        if (cnt == LAST) begin
                            rd_en <= 1'b0;
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + (AW+1)'(1);
                        end
                    end
                    DRAIN: begin
                        if (wr_en && wr_addr == LAST[AW-1:0]) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/poly_add_ctrl.md
POLY_ADD_CTRL -- requirements
Module: poly_add_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  N    256   coefficients per polynomial
  AW   8     address width, with 2**AW >= N
  DW   12    coefficient width (Q = 3329)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk      in   1   clock, rising edge
  rst_n    in   1   asynchronous active-low reset
  start    in   1   begin one polynomial addition, sampled in IDLE only
  abort    in   1   synchronous cancel of the current run
  busy     out  1   run in progress
  done     out  1   one-cycle completion pulse
  rd_en    out  1   read strobe to both operand banks
  rd_addr  out  AW  read address, shared by both banks
  rd_a     in   DW  bank A data, valid 1 cycle after rd_en
  rd_b     in   DW  bank B data, valid 1 cycle after rd_en
  add_a    out  DW  operand to the external combinational modular adder
  add_b    out  DW  operand to the external combinational modular adder
  add_res  in   DW  (add_a + add_b) mod Q, combinational return
  wr_en    out  1   result write strobe
  wr_addr  out  AW  result address
  wr_data  out  DW  result coefficient

Function
REQ-003 The FSM SHALL have four states: IDLE, ISSUE, DRAIN, FIN.
REQ-004 IDLE with start=1 SHALL move to ISSUE on the next edge, with the read counter cleared to 0.
REQ-005 In ISSUE the block SHALL assert rd_en=1 with rd_addr=k for k=0..N-1 on N consecutive cycles, with no gaps.
REQ-006 After issuing address N-1, ISSUE SHALL move to DRAIN.
REQ-007 DRAIN SHALL last until the write for address N-1 has been emitted, then move to FIN.
REQ-008 FIN SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-009 add_a and add_b SHALL equal rd_a and rd_b combinationally in the cycle after each rd_en (read-valid cycle); they are don't-care in all other cycles.
REQ-010 On the edge ending a read-valid cycle, wr_data SHALL register add_res, wr_addr SHALL register the matching address, and wr_en SHALL be set to 1; otherwise wr_en SHALL be registered to 0.
REQ-011 Latency: start sampled at edge t gives rd_addr k in cycle t+1+k, wr_en for k in cycle t+3+k, and done in cycle t+3+N.
REQ-012 Writes SHALL be in address order, one per cycle, exactly N per completed run, with no duplicates.
REQ-013 busy SHALL be 1 in ISSUE, DRAIN and FIN, and 0 in IDLE.
REQ-014 start while busy=1 SHALL be ignored, with no queueing.
REQ-015 start and done in the same cycle SHALL not start a new run; the FIN to IDLE transition takes priority.
REQ-016 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, drop all in-flight reads, and deassert rd_en and wr_en from that edge; done SHALL not pulse.
REQ-017 abort in IDLE SHALL have no effect; abort together with start in IDLE SHALL leave the block in IDLE.
REQ-018 The read counter SHALL be AW+1 bits so that N = 2**AW terminates without address wrap; rd_addr SHALL never exceed N-1.
REQ-019 The block SHALL perform no arithmetic on coefficient data; operands are passed through unchanged, and inputs >= Q are the adder's responsibility.

Reset
REQ-020 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, and counter=0, independent of clk.
REQ-021 Reset asserted mid-run SHALL discard the run; after release the block SHALL wait in IDLE for a fresh start.
REQ-022 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Verification
REQ-023 Run with N=4, A={3328,3000,0,1664}, B={0,329,0,1665}, start at t -> writes {3328,0,0,0} at addresses 0..3 in cycles t+3..t+6, done=1 in t+7 only.
REQ-024 Run with N=4, A={3000,3328,1,2}, B={330,3328,1,3327} -> wr_data {1,3327,2,0}, with no gaps on wr_en.
REQ-025 start held high for 20 cycles (N=4) -> exactly one run, and a second run begins only at the first start seen in IDLE after done.
REQ-026 abort in cycle t+3 (N=4) -> at most one write (address 0), then rd_en=wr_en=0 and busy=0 from t+4, with no done.
REQ-027 rst_n pulsed low in the middle of ISSUE -> all outputs 0 asynchronously, and a clean full run after the next start.
REQ-028 N=256, AW=8 -> 256 writes at addresses 0..255, rd_addr never wraps to 0, and busy is high for exactly 259 cycles.
